// File: rtl/uart_rx_capture_pkg.sv
// Shared types for the UART receive monitor.
//   rx_state_t  : receiver FSM states
//   PAR_*       : parity mode encodings for PARITY_MODE
//   rx_entry_t  : one captured frame as stored in the capture FIFO
package uart_rx_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Entry payload is sized for the widest frame; narrower frames are
    // zero-extended so the parity fold below is unaffected.
    localparam int MAX_DATA_BITS = 9;

    typedef struct packed {
        logic                     frame_err;
        logic                     parity_err;
        logic [MAX_DATA_BITS-1:0] data;
    } rx_entry_t;

    // True when the received parity bit disagrees with the configured mode.
    function automatic logic parity_error(input logic [MAX_DATA_BITS-1:0] data,
                                          input logic                     sample,
                                          input int                       mode);
        return (^data ^ sample) != (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_capture_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and sticky drop flag.
//   clk, rst  : clock, asynchronous active-high reset
//   wr, wdata : push request and data
//   rd        : pop head (ignored when empty)
//   clr       : clear sticky overflow
//   rdata     : head entry (zero when empty)
//   valid     : not empty
//   count     : entries stored, 0..2**ABITS
//   overflow  : sticky, set when a push was dropped because the FIFO was full
module uart_rx_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int ABITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    input  logic             clr,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic [ABITS:0]   count,
    output logic             overflow
);

    localparam int           DEPTH    = 1 << ABITS;
    localparam logic [ABITS:0] FULL_CNT = (ABITS+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ABITS-1:0] wptr, rptr;
    logic [ABITS:0]   cnt;
    logic             empty, full, do_rd, do_wr, drop;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign do_rd = rd & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign do_wr = wr & (~full | do_rd);
    assign drop  = wr & full & ~do_rd;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // New drop wins over a clear on the same edge.
            if (drop)     overflow <= 1'b1;
            else if (clr) overflow <= 1'b0;
        end
    end

    assign valid = ~empty;
    assign count = cnt;
    assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/uart_rx_capture.sv
// UART receive monitor with runtime baud scaler and show-ahead capture FIFO.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_scaler     : clocks per bit before speed-up, latched when a frame starts
//   i_rx         : serial line (asynchronous, idle high)
//   i_rd         : pop FIFO head
//   i_clr        : clear sticky o_overflow
//   o_valid      : FIFO not empty
//   o_data       : head payload
//   o_frame_err  : head stop-bit error
//   o_parity_err : head parity error
//   o_count      : stored entries
//   o_overflow   : sticky frame-dropped flag
//   o_break      : one-cycle strobe on a detected break
module uart_rx_capture
    import uart_rx_capture_pkg::*;
#(
    parameter int DATA_BITS        = 8,
    parameter int PARITY_MODE      = 0,
    parameter int STOP_BITS        = 1,
    parameter int SCALER_WIDTH     = 16,
    parameter int SIM_SPEEDUP_RATE = 0,
    parameter int FIFO_ABITS       = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [SCALER_WIDTH-1:0] i_scaler,
    input  logic                    i_rx,
    input  logic                    i_rd,
    input  logic                    i_clr,
    output logic                    o_valid,
    output logic [DATA_BITS-1:0]    o_data,
    output logic                    o_frame_err,
    output logic                    o_parity_err,
    output logic [FIFO_ABITS:0]     o_count,
    output logic                    o_overflow,
    output logic                    o_break
);

    localparam int CW = SCALER_WIDTH;

    // Two-flop synchroniser plus one history flop for edge detection.
    logic rx_meta, rx_s, rx_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // Bit period, floored at 2 so the half-period start offset is >= 1.
    logic [CW-1:0] eff_scaler, period_new;
    assign eff_scaler = i_scaler >> SIM_SPEEDUP_RATE;
    assign period_new = (eff_scaler < CW'(2)) ? CW'(2) : eff_scaler;

    rx_state_t            state_q, state_n;
    logic [CW-1:0]        period_q, period_n;
    logic [CW-1:0]        cnt_q, cnt_n;
    logic [3:0]           bit_q, bit_n;
    logic [DATA_BITS-1:0] sh_q, sh_n;
    logic                 pe_q, pe_n;
    logic                 fe_q, fe_n;
    logic                 pb_q, pb_n;     // raw parity sample, needed for break
    logic                 push, brk, brk_q;
    logic                 tick;

    assign tick = (cnt_q == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            period_q <= CW'(2);
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            pb_q     <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            period_q <= period_n;
            cnt_q    <= cnt_n;
            bit_q    <= bit_n;
            sh_q     <= sh_n;
            pe_q     <= pe_n;
            fe_q     <= fe_n;
            pb_q     <= pb_n;
            brk_q    <= brk;
        end
    end

    always_comb begin
        state_n  = state_q;
        period_n = period_q;
        cnt_n    = tick ? cnt_q : cnt_q - CW'(1);
        bit_n    = bit_q;
        sh_n     = sh_q;
        pe_n     = pe_q;
        fe_n     = fe_q;
        pb_n     = pb_q;
        push     = 1'b0;
        brk      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_d & ~rx_s) begin
                    state_n  = START;
                    period_n = period_new;
                    cnt_n    = (period_new >> 1) - CW'(1);
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_n = IDLE;     // glitch, not a real start bit
                    end else begin
                        state_n = DATA;
                        cnt_n   = period_q - CW'(1);
                        bit_n   = '0;
                        pe_n    = 1'b0;
                        fe_n    = 1'b0;
                        pb_n    = 1'b0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sh_n  = {rx_s, sh_q[DATA_BITS-1:1]};    // LSB first
                    cnt_n = period_q - CW'(1);
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_n   = '0;
                        state_n = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        bit_n = bit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    pb_n    = rx_s;
                    pe_n    = parity_error(MAX_DATA_BITS'(sh_q), rx_s, PARITY_MODE);
                    cnt_n   = period_q - CW'(1);
                    state_n = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    fe_n  = fe_q | ~rx_s;
                    cnt_n = period_q - CW'(1);
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        if ((sh_q == '0) && (PARITY_MODE == PAR_NONE || !pb_q) && fe_n)
                            brk = 1'b1;
                        else
                            push = 1'b1;
                        // A low stop bit means the line may still be held low;
                        // wait for it to return high before looking for a start.
                        state_n = rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        bit_n = bit_q + 4'd1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    rx_entry_t wr_entry, head;
    assign wr_entry.frame_err  = fe_n;
    assign wr_entry.parity_err = pe_q;
    assign wr_entry.data       = MAX_DATA_BITS'(sh_q);

    uart_rx_capture_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .ABITS (FIFO_ABITS)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .wr       (push),
        .wdata    (wr_entry),
        .rd       (i_rd),
        .clr      (i_clr),
        .rdata    (head),
        .valid    (o_valid),
        .count    (o_count),
        .overflow (o_overflow)
    );

    assign o_data       = head.data[DATA_BITS-1:0];
    assign o_frame_err  = head.frame_err;
    assign o_parity_err = head.parity_err;
    assign o_break      = brk_q;

    // Upper payload bits are zero for frames narrower than the entry.
    logic unused_head;
    assign unused_head = ^head.data;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture. dut0 uses default parameters with
// i_scaler = 8; dut1 uses even parity, a 4-entry FIFO and speed-up 3 with
// i_scaler = 64. Both run at 8 clocks per bit. Expected entries are queued
// as frames are sent; per-DUT monitors pop and compare while draining.
module tb_uart_rx_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] scaler0, scaler1;
    logic        rx0, rx1, clr0, clr1;
    logic        rd0 = 1'b0, rd1 = 1'b0;

    logic       v0, fe0, pe0, ov0, brk0;
    logic [7:0] d0;
    logic [4:0] cnt0;
    logic       v1, fe1, pe1, ov1, brk1;
    logic [7:0] d1;
    logic [2:0] cnt1;

    uart_rx_capture #(
        .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
        .SCALER_WIDTH(16), .SIM_SPEEDUP_RATE(0), .FIFO_ABITS(4)
    ) dut0 (
        .i_clk(clk), .i_rst(rst), .i_scaler(scaler0), .i_rx(rx0), .i_rd(rd0),
        .i_clr(clr0), .o_valid(v0), .o_data(d0), .o_frame_err(fe0),
        .o_parity_err(pe0), .o_count(cnt0), .o_overflow(ov0), .o_break(brk0)
    );

    uart_rx_capture #(
        .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
        .SCALER_WIDTH(16), .SIM_SPEEDUP_RATE(3), .FIFO_ABITS(2)
    ) dut1 (
        .i_clk(clk), .i_rst(rst), .i_scaler(scaler1), .i_rx(rx1), .i_rd(rd1),
        .i_clr(clr1), .o_valid(v1), .o_data(d1), .o_frame_err(fe1),
        .o_parity_err(pe1), .o_count(cnt1), .o_overflow(ov1), .o_break(brk1)
    );

    int total = 0;
    int bad   = 0;
    logic [9:0] q0[$], q1[$];   // {frame_err, parity_err, data}
    bit drain0 = 1'b0, drain1 = 1'b0;
    int brks0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: while draining, compare the presented head and pop it.
    always @(negedge clk) begin
        if (drain0 && v0) begin
            if (q0.size() == 0) chk("dut0_extra_entry", q0.size(), 1);
            else                chk("dut0_entry", {fe0, pe0, d0}, q0.pop_front());
            rd0 = 1'b1;
        end else begin
            rd0 = 1'b0;
        end
        if (brk0) brks0++;
    end

    always @(negedge clk) begin
        if (drain1 && v1) begin
            if (q1.size() == 0) chk("dut1_extra_entry", q1.size(), 1);
            else                chk("dut1_entry", {fe1, pe1, d1}, q1.pop_front());
            rd1 = 1'b1;
        end else begin
            rd1 = 1'b0;
        end
    end

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx0 = v;
        else        rx1 = v;
    endtask

    task automatic bit_time(input int d, input logic v);
        set_rx(d, v);
        repeat (8) @(negedge clk);
    endtask

    // par < 0: no parity bit; otherwise par[0] is sent as the parity bit.
    task automatic send_frame(input int d, input logic [7:0] data, input int par,
                              input logic stop);
        bit_time(d, 1'b0);
        for (int i = 0; i < 8; i++) bit_time(d, data[i]);
        if (par >= 0) bit_time(d, par[0]);
        bit_time(d, stop);
        set_rx(d, 1'b1);
    endtask

    task automatic drain(input int d);
        int n = 0;
        if (d == 0) drain0 = 1'b1;
        else        drain1 = 1'b1;
        while ((d == 0 ? (q0.size() != 0 || v0) : (q1.size() != 0 || v1)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(d == 0 ? "dut0_drain_done" : "dut1_drain_done", n < 200, 1);
        @(negedge clk);
        drain0 = 1'b0;
        drain1 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [7:0] ovf_bytes [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    int         ovf_par   [5] = '{1, 1, 0, 1, 0};   // even parity bits

    initial begin
        int b;
        rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
        scaler0 = 16'd8; scaler1 = 16'd64;
        clr0 = 1'b0; clr1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid0", v0, 0);
        chk("rst_count0", cnt0, 0);
        chk("rst_data0", d0, 0);
        chk("rst_ovf0", ov0, 0);
        chk("rst_break0", brk0, 0);
        chk("rst_valid1", v1, 0);
        chk("rst_count1", cnt1, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Clean 0x55; o_valid first seen after the 79th edge from the start bit.
        q0.push_back({2'b00, 8'h55});
        fork
            send_frame(0, 8'h55, -1, 1'b1);
            begin
                repeat (78) @(negedge clk);
                chk("t1_valid_early", v0, 0);
                @(negedge clk);
                chk("t1_valid_rise", v0, 1);
            end
        join
        chk("t1_count", cnt0, 1);
        chk("t1_data", d0, 8'h55);
        chk("t1_fe", fe0, 0);
        chk("t1_pe", pe0, 0);
        repeat (8) @(negedge clk);
        drain(0);

        // Framing error, then a clean frame.
        q0.push_back({2'b10, 8'h3C});
        send_frame(0, 8'h3C, -1, 1'b0);
        repeat (16) @(negedge clk);
        chk("t3_count", cnt0, 1);
        chk("t3_fe", fe0, 1);
        drain(0);
        q0.push_back({2'b00, 8'h11});
        send_frame(0, 8'h11, -1, 1'b1);
        repeat (16) @(negedge clk);
        chk("t3_next_count", cnt0, 1);
        drain(0);

        // Break: line low for two frame times.
        b = brks0;
        set_rx(0, 1'b0);
        repeat (160) @(negedge clk);
        set_rx(0, 1'b1);
        repeat (16) @(negedge clk);
        chk("t4_break_pulses", brks0 - b, 1);
        chk("t4_count", cnt0, 0);
        chk("t4_valid", v0, 0);

        // Parity: 0xA3 has four ones, so even parity bit 1 is wrong, 0 is right.
        q1.push_back({2'b01, 8'hA3});
        send_frame(1, 8'hA3, 1, 1'b1);
        repeat (16) @(negedge clk);
        chk("t2_pe", pe1, 1);
        chk("t2_fe", fe1, 0);
        chk("t2_data", d1, 8'hA3);
        drain(1);
        q1.push_back({2'b00, 8'hA3});
        send_frame(1, 8'hA3, 0, 1'b1);
        repeat (16) @(negedge clk);
        drain(1);

        // Overflow: five frames into four entries, fifth dropped.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) q1.push_back({2'b00, ovf_bytes[i]});
            send_frame(1, ovf_bytes[i], ovf_par[i], 1'b1);
            repeat (4) @(negedge clk);
        end
        chk("t5_count", cnt1, 4);
        chk("t5_ovf_set", ov1, 1);
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        chk("t5_ovf_clr", ov1, 0);
        drain(1);
        chk("t5_ovf_after_drain", ov1, 0);

        // Reset mid-frame with one entry stored: both are discarded.
        send_frame(1, 8'h5A, 0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t6_pre_count", cnt1, 1);
        bit_time(1, 1'b0);
        bit_time(1, 1'b1);
        bit_time(1, 1'b0);
        bit_time(1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", v1, 0);
        chk("t6_rst_count", cnt1, 0);
        chk("t6_rst_data", d1, 0);
        set_rx(1, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        q1.push_back({2'b00, 8'hF0});
        send_frame(1, 8'hF0, 0, 1'b1);
        repeat (16) @(negedge clk);
        chk("t6_count", cnt1, 1);
        chk("t6_data", d1, 8'hF0);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
